// File: rtl/vendo_coin_sched.sv
// Coin-event scheduler: queues P1/P5 coin pulses and issues them one at a time
// to the vending core while it is in a coin-accepting state (000 or 001).
module vendo_coin_sched #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   coin_p1,
    input  logic                   coin_p5,
    input  logic [2:0]             core_cstate,
    input  logic                   core_disp,
    input  logic                   core_change,
    output logic                   core_p1,
    output logic                   core_p5,
    output logic [$clog2(DEPTH):0] fifo_level,
    output logic                   overflow,
    output logic                   busy,
    output logic [CNT_W-1:0]       vend_count,
    output logic [CNT_W-1:0]       change_count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, ISSUE, SETTLE} state_t;

    state_t           state;
    state_t           state_next;
    logic [DEPTH-1:0] mem;          // 0 = P1, 1 = P5
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic             core_ready;
    logic             pop;
    logic             head;
    logic             keep_p1;
    logic             keep_p5;
    logic             change_prev;
    logic [AW:0]      free_slots;
    logic [AW:0]      push_cnt;

    assign core_ready = (core_cstate == 3'b000) || (core_cstate == 3'b001);
    assign head       = mem[rd_ptr];

    // A slot freed by this cycle's pop is usable by this cycle's push; P1 wins the last slot.
    assign free_slots = FULL - fifo_level + {{AW{1'b0}}, pop};
    assign keep_p1    = coin_p1 && (free_slots != '0);
    assign keep_p5    = coin_p5 && (free_slots > {{AW{1'b0}}, keep_p1});
    assign push_cnt   = {{AW{1'b0}}, keep_p1} + {{AW{1'b0}}, keep_p5};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    // SETTLE may pop directly so queued coins issue every 2 cycles.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (pop) state_next = ISSUE;
            ISSUE:   state_next = SETTLE;
            SETTLE:  state_next = pop ? ISSUE : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        pop  = ((state == IDLE) || (state == SETTLE)) && (fifo_level != '0) && core_ready;
        busy = (fifo_level != '0) || (state != IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem        <= '0;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            fifo_level <= '0;
            overflow   <= 1'b0;
            core_p1    <= 1'b0;
            core_p5    <= 1'b0;
        end else begin
            if (keep_p1) mem[wr_ptr] <= 1'b0;
            if (keep_p5) mem[wr_ptr + AW'(keep_p1)] <= 1'b1;
            wr_ptr     <= wr_ptr + AW'(push_cnt);
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            fifo_level <= fifo_level + push_cnt - {{AW{1'b0}}, pop};
            if ((coin_p1 && !keep_p1) || (coin_p5 && !keep_p5)) overflow <= 1'b1;
            core_p1    <= pop && !head;
            core_p5    <= pop && head;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vend_count   <= '0;
            change_count <= '0;
            change_prev  <= 1'b0;
        end else begin
            vend_count   <= vend_count + CNT_W'(core_disp);
            change_count <= change_count + CNT_W'(core_change && !change_prev);
            change_prev  <= core_change;
        end
    end
endmodule
